// File: rtl/operand_loader.sv
// Operand loader: captures minuend A then subtrahend B from a shared switch bank
// using one debounced LOAD button; CLEAR returns to operand A entry.
// Latency: LOAD first sampled high at edge k -> A/B update at edge k+DEBOUNCE_CYCLES+2.
module operand_loader #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             operands_valid,
  output logic [1:0]       state
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    READY  = 2'b10
  } state_t;

  logic          load_s1;
  logic          load_s;
  logic          clear_s1;
  logic          clear_s;
  logic          stable_lvl;
  logic [CW-1:0] cnt;
  logic          load_pulse;
  state_t        state_q;

  // Two-flop synchronisers for both raw pushbuttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_s1  <= 1'b0;
      load_s   <= 1'b0;
      clear_s1 <= 1'b0;
      clear_s  <= 1'b0;
    end else begin
      load_s1  <= btn_load;
      load_s   <= load_s1;
      clear_s1 <= btn_clear;
      clear_s  <= clear_s1;
    end
  end

  // Debounce LOAD: accept a new level only after DEBOUNCE_CYCLES consecutive
  // mismatching samples; a rising acceptance emits a single-cycle load_pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_lvl <= 1'b0;
      cnt        <= '0;
      load_pulse <= 1'b0;
    end else begin
      load_pulse <= 1'b0;
      if (load_s == stable_lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable_lvl <= load_s;
        cnt        <= '0;
        load_pulse <= load_s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Operand-entry FSM; CLEAR wins over a coincident load pulse and the
  // unused encoding falls back to WAIT_A.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= WAIT_A;
      A              <= '0;
      B              <= '0;
      operands_valid <= 1'b0;
    end else if (clear_s) begin
      state_q        <= WAIT_A;
      A              <= '0;
      B              <= '0;
      operands_valid <= 1'b0;
    end else begin
      case (state_q)
        WAIT_A: begin
          if (load_pulse) begin
            A       <= sw;
            state_q <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (load_pulse) begin
            B              <= sw;
            operands_valid <= 1'b1;
            state_q        <= READY;
          end
        end
        READY: begin
          if (load_pulse) begin
            A              <= sw;
            operands_valid <= 1'b0;
            state_q        <= WAIT_B;
          end
        end
        default: begin
          state_q        <= WAIT_A;
          operands_valid <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic       btn_load;
  logic       btn_clear;
  logic [3:0] A;
  logic [3:0] B;
  logic       operands_valid;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  operand_loader #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .sw             (sw),
    .btn_load       (btn_load),
    .btn_clear      (btn_clear),
    .A              (A),
    .B              (B),
    .operands_valid (operands_valid),
    .state          (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] val, input int n_high);
    sw       = val;
    btn_load = 1'b1;
    repeat (n_high) tick();
    btn_load = 1'b0;
    repeat (10) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    btn_load  = 1'b0;
    btn_clear = 1'b0;
    sw        = 4'd0;
    do_reset();
    checks++;
    if ({A, B, operands_valid, state} !== 11'b0) begin
      errors++;
      $display("FAIL reset: A=%0d B=%0d valid=%0b state=%b, want all 0", A, B, operands_valid, state);
    end
  endtask

  task automatic test_entry();
    do_reset();
    press(4'd7, 10);
    checks++;
    if (A !== 4'd7 || state !== 2'b01 || operands_valid !== 1'b0) begin
      errors++;
      $display("FAIL entry_a: A=%0d state=%b valid=%0b, want A=7 state=01 valid=0", A, state, operands_valid);
    end
    sw = 4'd14;
    repeat (3) tick();
    checks++;
    if (A !== 4'd7) begin
      errors++;
      $display("FAIL sw_no_load: A=%0d, want 7", A);
    end
    press(4'd3, 10);
    checks++;
    if (A !== 4'd7 || B !== 4'd3 || operands_valid !== 1'b1 || state !== 2'b10) begin
      errors++;
      $display("FAIL entry_b: A=%0d B=%0d valid=%0b state=%b, want 7 3 1 10", A, B, operands_valid, state);
    end
    checks++;
    if (4'(A - B) !== 4'd4) begin
      errors++;
      $display("FAIL entry_diff: A-B=%0d, want 4", 4'(A - B));
    end
  endtask

  task automatic test_bounce();
    do_reset();
    sw = 4'd5;
    btn_load = 1'b1; repeat (3) tick();
    btn_load = 1'b0; tick();
    btn_load = 1'b1; repeat (3) tick();
    btn_load = 1'b0; repeat (10) tick();
    checks++;
    if (A !== 4'd0 || state !== 2'b00) begin
      errors++;
      $display("FAIL bounce_reject: A=%0d state=%b, want A=0 state=00", A, state);
    end
    btn_load = 1'b1; repeat (3) tick();
    btn_load = 1'b0; tick();
    btn_load = 1'b1; repeat (3) tick();
    btn_load = 1'b0; tick();
    press(4'd5, 6);
    checks++;
    if (A !== 4'd5 || state !== 2'b01) begin
      errors++;
      $display("FAIL bounce_accept: A=%0d state=%b, want A=5 state=01", A, state);
    end
  endtask

  task automatic test_latency();
    int first_change;
    int state_changes;
    logic [1:0] prev_state;
    do_reset();
    sw = 4'd10;
    btn_load = 1'b1;
    first_change = -1;
    state_changes = 0;
    prev_state = state;
    // After tick n, edge k+n-1 has occurred.
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (A === 4'd10 && first_change < 0) first_change = n - 1;
      if (state !== prev_state) state_changes++;
      prev_state = state;
    end
    btn_load = 1'b0;
    repeat (10) tick();
    if (state !== prev_state) state_changes++;
    checks++;
    if (first_change !== 6) begin
      errors++;
      $display("FAIL latency: A updated at edge k+%0d, want k+6", first_change);
    end
    checks++;
    if (state_changes !== 1 || state !== 2'b01 || A !== 4'd10) begin
      errors++;
      $display("FAIL single_pulse: changes=%0d state=%b A=%0d, want 1 01 10", state_changes, state, A);
    end
  endtask

  task automatic test_clear_priority();
    do_reset();
    press(4'd9, 6);
    checks++;
    if (A !== 4'd9 || state !== 2'b01) begin
      errors++;
      $display("FAIL clear_setup: A=%0d state=%b, want 9 01", A, state);
    end
    sw = 4'd4;
    btn_load = 1'b1;
    repeat (3) tick();
    btn_clear = 1'b1;
    repeat (8) tick();
    btn_clear = 1'b0;
    btn_load  = 1'b0;
    repeat (10) tick();
    checks++;
    if (A !== 4'd0 || B !== 4'd0 || state !== 2'b00 || operands_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_priority: A=%0d B=%0d state=%b valid=%0b, want 0 0 00 0", A, B, state, operands_valid);
    end
  endtask

  task automatic test_reload();
    do_reset();
    press(4'd2, 6);
    press(4'd5, 6);
    checks++;
    if (A !== 4'd2 || B !== 4'd5 || operands_valid !== 1'b1 || state !== 2'b10) begin
      errors++;
      $display("FAIL reload_setup: A=%0d B=%0d valid=%0b state=%b, want 2 5 1 10", A, B, operands_valid, state);
    end
    press(4'd12, 6);
    checks++;
    if (A !== 4'd12 || B !== 4'd5 || operands_valid !== 1'b0 || state !== 2'b01) begin
      errors++;
      $display("FAIL reload_a: A=%0d B=%0d valid=%0b state=%b, want 12 5 0 01", A, B, operands_valid, state);
    end
    press(4'd1, 6);
    checks++;
    if (A !== 4'd12 || B !== 4'd1 || operands_valid !== 1'b1 || state !== 2'b10) begin
      errors++;
      $display("FAIL reload_b: A=%0d B=%0d valid=%0b state=%b, want 12 1 1 10", A, B, operands_valid, state);
    end
    checks++;
    if (4'(A - B) !== 4'd11) begin
      errors++;
      $display("FAIL reload_diff: A-B=%0d, want 11", 4'(A - B));
    end
  endtask

  task automatic test_reset_mid_debounce();
    // Starts in READY (A=12, B=1) left by test_reload.
    sw = 4'd8;
    btn_load = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({A, B, operands_valid, state} !== 11'b0) begin
      errors++;
      $display("FAIL rst_mid: A=%0d B=%0d valid=%0b state=%b, want all 0", A, B, operands_valid, state);
    end
    tick();
    btn_load = 1'b0;
    repeat (10) tick();
    checks++;
    if (A !== 4'd0 || state !== 2'b00) begin
      errors++;
      $display("FAIL rst_no_capture: A=%0d state=%b, want 0 00", A, state);
    end
    press(4'd6, 8);
    checks++;
    if (A !== 4'd6 || state !== 2'b01) begin
      errors++;
      $display("FAIL rst_recover: A=%0d state=%b, want 6 01", A, state);
    end
  endtask

  initial begin
    rst       = 1'b1;
    sw        = 4'd0;
    btn_load  = 1'b0;
    btn_clear = 1'b0;
    test_reset();
    test_entry();
    test_bounce();
    test_latency();
    test_clear_priority();
    test_reload();
    test_reset_mid_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
